// File: rtl/alu_sched_pkg.sv
// Shared definitions for the round-robin ALU scheduler.
// Provides:
//   - ALU opcode encodings (NOP/3'b110 produce a zero result)
//   - default ALU register latency
//   - the in-flight tag type carried alongside ALU data
package alu_sched_pkg;

  localparam int ALU_LAT_DEF = 2;

  localparam logic [2:0] ADD    = 3'd0;
  localparam logic [2:0] SUB    = 3'd1;
  localparam logic [2:0] MUL    = 3'd2;
  localparam logic [2:0] AND_OP = 3'd3;
  localparam logic [2:0] OR_OP  = 3'd4;
  localparam logic [2:0] XOR_OP = 3'd5;
  localparam logic [2:0] NOP    = 3'd7;

  // The id field is sized for the largest supported requester count (8);
  // smaller configurations use only the low $clog2(NUM_REQ) bits.
  localparam int TAG_ID_W = 3;

  typedef struct packed {
    logic                valid;
    logic [TAG_ID_W-1:0] id;
  } tag_t;

endpackage

// File: rtl/alu_rr_scheduler_rr_arbiter.sv
// Round-robin arbiter, reusable by any shared-resource controller.
// Ports:
//   req_i      per-requester request
//   pointer_i  index of the most recently granted requester
//   enable_i   when low, no grant is produced
//   grant_o    one-hot grant (all zero when nothing is granted)
//   idx_o      encoded index of the granted requester (0 when none)
// The search starts at pointer_i+1 and wraps modulo NUM_REQ, so the
// last winner has the lowest priority on the next round.
module rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [IDX_W-1:0]   pointer_i,
  input  logic               enable_i,
  output logic [NUM_REQ-1:0] grant_o,
  output logic [IDX_W-1:0]   idx_o
);

  logic found;
  int   cand;

  always_comb begin
    grant_o = '0;
    idx_o   = '0;
    found   = 1'b0;
    cand    = 0;
    for (int off = 1; off <= NUM_REQ; off++) begin
      cand = (int'(pointer_i) + off) % NUM_REQ;
      if (enable_i && !found && req_i[cand]) begin
        found         = 1'b1;
        grant_o[cand] = 1'b1;
        idx_o         = IDX_W'(cand);
      end
    end
  end

endmodule

// File: rtl/alu_rr_scheduler.sv
// Shares one pipelined ALU between NUM_REQ requesters.
// Ports:
//   clk, reset            clock, synchronous active-high reset
//   req_valid/req_ready   per-requester issue handshake (one-hot ready)
//   req_a/req_b/req_op    packed operands/opcode, requester i at slice i
//   hold                  blocks new grants; in-flight ops still drain
//   alu_a/alu_b/alu_op    registered operands driven into the ALU
//   alu_result            ALU output, ALU_LAT cycles after alu_* are set
//   rsp_valid/rsp_data    one-hot 1-cycle response pulse and its data
//   busy                  an op is in flight or a response is pending
//
// Handshake: an op is transferred at a rising edge where
// req_valid[i] & req_ready[i] is high. ready may depend on valid; valid
// must never depend on ready. An ungranted requester keeps valid and its
// operands stable. Responses have no back-pressure: rsp_valid is a single
// cycle pulse that the requester must sink.
//
// A tag pipeline of ALU_LAT+1 stages follows the ALU data; stage j holds
// the owner of the data that is j cycles old. The last stage qualifies
// alu_result, which also masks the unreset ALU output after reset.
module alu_rr_scheduler
  import alu_sched_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int ALU_LAT = ALU_LAT_DEF
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NUM_REQ-1:0]   req_valid,
  output logic [NUM_REQ-1:0]   req_ready,
  input  logic [8*NUM_REQ-1:0] req_a,
  input  logic [8*NUM_REQ-1:0] req_b,
  input  logic [3*NUM_REQ-1:0] req_op,
  input  logic                 hold,
  output logic [7:0]           alu_a,
  output logic [7:0]           alu_b,
  output logic [2:0]           alu_op,
  input  logic [15:0]          alu_result,
  output logic [NUM_REQ-1:0]   rsp_valid,
  output logic [15:0]          rsp_data,
  output logic                 busy
);

  localparam int IDX_W = $clog2(NUM_REQ);
  localparam int LAST  = ALU_LAT;

  logic [IDX_W-1:0]   ptr_q, ptr_d;
  logic [IDX_W-1:0]   gnt_idx;
  logic [NUM_REQ-1:0] grant;
  logic               hs;

  logic [7:0]  sel_a, sel_b;
  logic [2:0]  sel_op;
  logic [7:0]  alu_a_q, alu_a_d;
  logic [7:0]  alu_b_q, alu_b_d;
  logic [2:0]  alu_op_q, alu_op_d;
  tag_t        tag_q [LAST+1];
  tag_t        tag_d [LAST+1];
  logic [NUM_REQ-1:0] rsp_valid_q, rsp_valid_d;
  logic [15:0]        rsp_data_q, rsp_data_d;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_arb (
    .req_i     (req_valid),
    .pointer_i (ptr_q),
    .enable_i  (!hold && !reset),
    .grant_o   (grant),
    .idx_o     (gnt_idx)
  );

  assign req_ready = grant;
  assign hs        = |(grant & req_valid);

  // Grant is one-hot, so an OR-mux selects the winner's operands.
  always_comb begin
    sel_a  = '0;
    sel_b  = '0;
    sel_op = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant[i]) begin
        sel_a  = sel_a  | req_a[8*i +: 8];
        sel_b  = sel_b  | req_b[8*i +: 8];
        sel_op = sel_op | req_op[3*i +: 3];
      end
    end
  end

  always_comb begin
    ptr_d    = ptr_q;
    alu_a_d  = '0;
    alu_b_d  = '0;
    alu_op_d = NOP;
    tag_d[0] = '0;
    if (hs) begin
      ptr_d          = gnt_idx;
      alu_a_d        = sel_a;
      alu_b_d        = sel_b;
      alu_op_d       = sel_op;
      tag_d[0].valid = 1'b1;
      tag_d[0].id    = TAG_ID_W'(gnt_idx);
    end
    for (int j = 1; j <= LAST; j++) begin
      tag_d[j] = tag_q[j-1];
    end
    rsp_valid_d = '0;
    rsp_data_d  = rsp_data_q;
    if (tag_q[LAST].valid) begin
      rsp_valid_d = NUM_REQ'(1) << tag_q[LAST].id;
      rsp_data_d  = alu_result;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ptr_q       <= IDX_W'(NUM_REQ - 1);
      alu_a_q     <= '0;
      alu_b_q     <= '0;
      alu_op_q    <= NOP;
      rsp_valid_q <= '0;
      rsp_data_q  <= '0;
      for (int j = 0; j <= LAST; j++) begin
        tag_q[j] <= '0;
      end
    end else begin
      ptr_q       <= ptr_d;
      alu_a_q     <= alu_a_d;
      alu_b_q     <= alu_b_d;
      alu_op_q    <= alu_op_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      for (int j = 0; j <= LAST; j++) begin
        tag_q[j] <= tag_d[j];
      end
    end
  end

  // Only registered sources, so busy drops the cycle after reset.
  always_comb begin
    busy = |rsp_valid_q;
    for (int j = 0; j <= LAST; j++) begin
      busy = busy | tag_q[j].valid;
    end
  end

  assign alu_a     = alu_a_q;
  assign alu_b     = alu_b_q;
  assign alu_op    = alu_op_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_data  = rsp_data_q;

endmodule

// File: doc/alu_rr_scheduler.md
Name: alu_rr_scheduler

Overview:
- Shares one pipelined 8-bit ALU (2-cycle registered latency, 16-bit result) between NUM_REQ requesters.
- Each requester uses a valid/ready issue handshake; the ALU takes at most one accepted op per cycle, chosen round-robin.
- A tag pipeline tracks which requester owns each in-flight op, so every result is returned to its issuer.
- Sits between requester blocks and the ALU instance; it is the only driver of the ALU's a/b/op inputs.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- ALU_LAT, 2, ALU register stages from a/b/op sampling edge to valid result output.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- req_valid  in  NUM_REQ  per-requester op valid
- req_ready  out  NUM_REQ  one-hot grant; handshake when valid&ready at posedge
- req_a  in  8*NUM_REQ  operand A, requester i at [8i+7:8i]
- req_b  in  8*NUM_REQ  operand B, same packing
- req_op  in  3*NUM_REQ  opcode, requester i at [3i+2:3i]
- hold  in  1  when high, no new grants; in-flight ops drain
- alu_a  out  8  registered operand A to ALU
- alu_b  out  8  registered operand B to ALU
- alu_op  out  3  registered opcode to ALU
- alu_result  in  16  ALU result output
- rsp_valid  out  NUM_REQ  one-hot, 1-cycle pulse: result for requester i
- rsp_data  out  16  result data, valid while any rsp_valid bit is set
- busy  out  1  high while any op is in flight or a response is pending

Behaviour:
- Clocking and reset: one clock (clk). Reset is synchronous and active-high (reset); polarity and synchronicity are fixed.
- Reset values: alu_a=0, alu_b=0, alu_op=NOP (3'b111, ALU yields 0), rsp_valid=0, rsp_data=0, all tags invalid, rr pointer=NUM_REQ-1 (requester 0 has first priority).
- Grant logic (combinational):
  - Search starts at pointer+1 modulo NUM_REQ; the first i with req_valid[i] gets req_ready[i]=1.
  - All ready bits are 0 if hold or reset is high.
  - ready may depend on valid; valid must not depend on ready.
- Issue at handshake edge k:
  - alu_a/b/op <= the granted requester's operands.
  - Tag stage0 <= {valid=1, id=i}.
  - pointer <= i.
- With no handshake at an edge: alu_op <= NOP, alu_a/b <= 0, stage0.valid <= 0; pointer is unchanged.
- Tag pipeline: ALU_LAT+1 stages, shifting every cycle with no stall. Stage j is aligned with the ALU data that is j cycles old.
- Response capture at edge k+ALU_LAT+1 (k+3 by default):
  - rsp_valid <= onehot(last stage id) if last stage valid, else 0.
  - rsp_data <= alu_result when last stage valid; otherwise it holds its previous value.
- Latency: handshake at edge k gives rsp_valid high from edge k+3 to k+4. Throughput: 1 op/cycle. Responses return in issue order.
- No response back-pressure: requesters must sink rsp_valid in the pulse cycle.
- Arithmetic is performed by the ALU. This block passes operands through unmodified and never alters results:
  - SUB wraps in 16 bits.
  - Opcodes 3'b110 and 3'b111 return 16'h0000; they are accepted and answered like any other op.
- The ALU output stage is not reset, so its value after reset is undefined. The tag pipeline masks it because no valid tag exists.
- Reset mid-operation: all in-flight tags are dropped, no rsp_valid follows, and busy=0 from the first cycle after the reset edge.
- hold asserted mid-stream: ops already accepted complete normally. busy falls the cycle after the final response pulse.
- A requester that is ungranted but keeps valid high must hold its operands stable until granted. Round-robin guarantees a grant within NUM_REQ cycles when hold=0.
- busy = OR of all tag valids OR any rsp_valid bit (registered sources only).

Decomposition:
- Package alu_sched_pkg:
  - Opcode constants ADD=0, SUB=1, MUL=2, AND_OP=3, OR_OP=4, XOR_OP=5, NOP=7.
  - ALU_LAT default.
  - Tag struct/type {valid, id[$clog2(NUM_REQ)-1:0]}.
- Sub-module rr_arbiter: parameterised NUM_REQ; inputs req, pointer, enable; outputs one-hot grant and encoded index. It is reusable by other shared-resource controllers.

Test Plan:
- Single op: req0 ADD a=200 b=100, accepted at edge k -> rsp_valid=4'b0001 for exactly the k+3..k+4 cycle, rsp_data=16'd300; other requesters never see rsp_valid.
- All four requesters valid continuously, hold=0 -> req_ready sequence 0001,0010,0100,1000,0001...; responses in the same order, each 3 edges after its handshake, with no gaps.
- Width checks: MUL 255*255 -> 16'hFE01. SUB 5-10 -> 16'hFFFB. XOR 8'hF0^8'h3C -> 16'h00CC. Opcode 3'b110 -> 16'h0000 with rsp_valid asserted.
- Fairness: req1 and req3 held valid, req0 pulsed on alternate cycles -> no requester waits more than NUM_REQ cycles; pointer advances only on a handshake.
- Reset with 3 ops in flight (issued at k, k+1, k+2; reset high at k+2) -> no rsp_valid afterwards, busy=0 at k+3, alu_op=NOP, first post-reset grant goes to req0.
- hold=1 with all requesters valid -> req_ready=0 throughout. Ops accepted before hold still return. busy drops one cycle after the last rsp_valid pulse.
